// File: rtl/dbg_pkg.sv
// Shared debug-bus types: segment/address layout, host command opcodes and
// the host-interface state encoding.
package dbg;

  typedef enum logic [3:0] {
    CTL = 4'h0,
    ROM = 4'h1,
    RAM = 4'h2
  } seg_t;

  typedef logic [11:0] seg_addr_t;

  typedef struct packed {
    seg_t      seg;
    seg_addr_t addr;
  } addr_t;

  localparam seg_addr_t Ctl_pc_lo_addr   = 12'h001;
  localparam seg_addr_t Ctl_sys_rst_addr = 12'h010;

  localparam logic [7:0] Op_write = 8'h57;
  localparam logic [7:0] Op_read  = 8'h52;
  localparam logic [7:0] Op_load  = 8'h4C;
  localparam logic [7:0] Rsp_ack  = 8'h06;
  localparam logic [7:0] Rsp_nak  = 8'h15;

  localparam int unsigned Rd_lat   = 2;
  localparam int unsigned Rd_cnt_w = 2;

  localparam addr_t Park_addr = '{seg: CTL, addr: Ctl_sys_rst_addr};

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    LEN,
    DATA,
    WRITE,
    RD_WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dbg_timeout.sv
// Inter-byte idle counter; expired rises after Timeout_cycles enabled cycles
// without a clear.
module dbg_timeout #(
  parameter logic [15:0] Timeout_cycles = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned Cnt_w = 16;

  logic [Cnt_w-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear || !enable) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (!expired) begin
      cnt     <= cnt + Cnt_w'(1);
      expired <= (cnt == Cnt_w'(Timeout_cycles - 16'd1));
    end
  end

endmodule

// File: rtl/dbg_host_if.sv
// Host byte-stream command decoder driving the dbg_ctl register bus
// (single write, single read, burst write) with ACK/NAK/data responses.
module dbg_host_if #(
  parameter logic [15:0] Timeout_cycles = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output dbg::addr_t  dbg_addr,
  output logic        dbg_wen,
  output logic [7:0]  dbg_wdata,
  input  logic [7:0]  dbg_rdata
);

  import dbg::*;

  state_t              st;
  logic [7:0]          op;
  addr_t               tgt;
  logic [7:0]          cnt;
  logic [Rd_cnt_w-1:0] rd_cnt;
  logic                acc;
  logic                to_en;
  logic                expired;

  assign acc   = rx_valid && rx_ready;
  assign to_en = (st == ADDR_HI) || (st == ADDR_LO) || (st == LEN) || (st == DATA);

  dbg_timeout #(.Timeout_cycles(Timeout_cycles)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (acc),
    .enable  (to_en),
    .expired (expired)
  );

  // ROM seg only ever reaches dbg_addr while in WRITE; everything else parks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      op        <= Op_write;
      tgt       <= Park_addr;
      cnt       <= 8'h00;
      rd_cnt    <= '0;
      rx_ready  <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      dbg_wen   <= 1'b0;
      dbg_wdata <= 8'h00;
      dbg_addr  <= Park_addr;
    end else begin
      case (st)
        IDLE: begin
          if (acc) begin
            if (rx_data == Op_write || rx_data == Op_read || rx_data == Op_load) begin
              op <= rx_data;
              st <= ADDR_HI;
            end else begin
              tx_data  <= Rsp_nak;
              tx_valid <= 1'b1;
              rx_ready <= 1'b0;
              st       <= RESP;
            end
          end
        end
        ADDR_HI: begin
          if (acc) begin
            tgt <= '{seg: seg_t'(rx_data[7:4]), addr: {rx_data[3:0], tgt.addr[7:0]}};
            st  <= ADDR_LO;
          end else if (expired) begin
            st <= IDLE;
          end
        end
        ADDR_LO: begin
          if (acc) begin
            tgt.addr[7:0] <= rx_data;
            if (op == Op_read) begin
              rx_ready <= 1'b0;
              rd_cnt   <= '0;
              st       <= RD_WAIT;
              if (tgt.seg != ROM)
                dbg_addr <= '{seg: tgt.seg, addr: {tgt.addr[11:8], rx_data}};
            end else if (op == Op_load) begin
              st <= LEN;
            end else begin
              st <= DATA;
            end
          end else if (expired) begin
            st <= IDLE;
          end
        end
        LEN: begin
          if (acc) begin
            cnt <= rx_data;
            st  <= DATA;
          end else if (expired) begin
            st <= IDLE;
          end
        end
        DATA: begin
          if (acc) begin
            dbg_wdata <= rx_data;
            dbg_wen   <= 1'b1;
            dbg_addr  <= tgt;
            rx_ready  <= 1'b0;
            st        <= WRITE;
          end else if (expired) begin
            st <= IDLE;
          end
        end
        WRITE: begin
          dbg_wen  <= 1'b0;
          dbg_addr <= Park_addr;
          if (op == Op_load && cnt != 8'h00) begin
            cnt      <= cnt - 8'd1;
            tgt.addr <= 12'(tgt.addr + 12'd1);
            rx_ready <= 1'b1;
            st       <= DATA;
          end else begin
            tx_data  <= Rsp_ack;
            tx_valid <= 1'b1;
            st       <= RESP;
          end
        end
        RD_WAIT: begin
          rd_cnt <= rd_cnt + Rd_cnt_w'(1);
          if (rd_cnt == Rd_cnt_w'(Rd_lat - 1)) begin
            tx_data  <= (tgt.seg == ROM) ? Rsp_nak : dbg_rdata;
            tx_valid <= 1'b1;
            dbg_addr <= Park_addr;
            st       <= RESP;
          end
        end
        RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            st       <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_host_if.sv
// Directed bench for dbg_host_if with a small registered dbg_ctl read model.
module tb_dbg_host_if;
  import dbg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  addr_t      dbg_addr;
  logic       dbg_wen;
  logic [7:0] dbg_wdata;
  logic [7:0] dbg_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int rom_cyc = 0;
  int pc_hits = 0;

  always #5 clk = ~clk;

  dbg_host_if #(.Timeout_cycles(16'd20)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .dbg_addr  (dbg_addr),
    .dbg_wen   (dbg_wen),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata)
  );

  // dbg_ctl stand-in: registered read data, CTL pc_lo reads 0x3C
  always @(posedge clk) begin
    dbg_rdata <= (dbg_addr == '{seg: CTL, addr: Ctl_pc_lo_addr}) ? 8'h3C : 8'h00;
    if (!rst) begin
      if (dbg_wen) begin
        wa.push_back(dbg_addr);
        wd.push_back(dbg_wdata);
      end
      if (dbg_addr.seg == ROM) rom_cyc++;
      if (dbg_addr == '{seg: CTL, addr: Ctl_pc_lo_addr}) pc_hits++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic get_resp(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(tx_valid), 32'd1);
    check({tag, "_data"}, 32'(tx_data), 32'(exp));
    tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask

  initial begin
    int w0;
    int r0;
    int p0;
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_wen", 32'(dbg_wen), 32'd0);
    check("rst_wdata", 32'(dbg_wdata), 32'h00);
    check("rst_addr", 32'(dbg_addr), 32'h0010);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single write
    w0 = wa.size();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    get_resp("wr_ack", 8'h06);
    check("wr_count", 32'(wa.size() - w0), 32'd1);
    check("wr_addr", 32'(wa[w0]), 32'h0000);
    check("wr_data", 32'(wd[w0]), 32'h07);
    check("wr_park", 32'(dbg_addr), 32'h0010);

    // single read
    w0 = wa.size(); p0 = pc_hits;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    get_resp("rd", 8'h3C);
    check("rd_no_wen", 32'(wa.size() - w0), 32'd0);
    check("rd_addr_cycles", 32'(pc_hits - p0), 32'(Rd_lat));

    // burst write into ROM with 12-bit wrap
    w0 = wa.size(); r0 = rom_cyc;
    send_byte(8'h4C); send_byte(8'h1F); send_byte(8'hFE); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    get_resp("burst_ack", 8'h06);
    check("burst_count", 32'(wa.size() - w0), 32'd3);
    check("burst_a0", 32'(wa[w0]), 32'h1FFE);
    check("burst_d0", 32'(wd[w0]), 32'hAA);
    check("burst_a1", 32'(wa[w0+1]), 32'h1FFF);
    check("burst_d1", 32'(wd[w0+1]), 32'hBB);
    check("burst_a2", 32'(wa[w0+2]), 32'h1000);
    check("burst_d2", 32'(wd[w0+2]), 32'hCC);
    check("burst_rom_cycles", 32'(rom_cyc - r0), 32'd3);

    // bad opcode then a normal write
    send_byte(8'h5A);
    get_resp("nak", 8'h15);
    w0 = wa.size();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h05); send_byte(8'h11);
    get_resp("post_nak_ack", 8'h06);
    check("post_nak_addr", 32'(wa[w0]), 32'h0005);
    check("post_nak_data", 32'(wd[w0]), 32'h11);

    // stall mid-command past the timeout
    w0 = wa.size();
    send_byte(8'h57); send_byte(8'h00);
    repeat (25) @(negedge clk);
    check("to_no_tx", 32'(tx_valid), 32'd0);
    check("to_rx_ready", 32'(rx_ready), 32'd1);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    get_resp("to_read", 8'h3C);
    check("to_no_write", 32'(wa.size() - w0), 32'd0);

    // ROM read is refused without presenting ROM seg
    r0 = rom_cyc;
    send_byte(8'h52); send_byte(8'h10); send_byte(8'h00);
    get_resp("rom_rd", 8'h15);
    check("rom_rd_no_seg", 32'(rom_cyc - r0), 32'd0);

    // response held indefinitely, no timeout, rx blocked
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    repeat (40) @(negedge clk);
    check("hold_valid", 32'(tx_valid), 32'd1);
    check("hold_data", 32'(tx_data), 32'h3C);
    check("hold_rx_ready", 32'(rx_ready), 32'd0);
    get_resp("hold", 8'h3C);

    // 256-byte burst
    w0 = wa.size();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h20); send_byte(8'hFF);
    for (int i = 0; i < 255; i++) send_byte(8'(i));
    @(negedge clk);
    check("long_no_early_ack", 32'(tx_valid), 32'd0);
    send_byte(8'hFF);
    get_resp("long_ack", 8'h06);
    check("long_count", 32'(wa.size() - w0), 32'd256);
    check("long_last_addr", 32'(wa[w0+255]), 32'h011F);
    check("long_last_data", 32'(wd[w0+255]), 32'hFF);
    check("long_mid_data", 32'(wd[w0+100]), 32'd100);

    // reset in the middle of a 4-byte burst
    w0 = wa.size();
    send_byte(8'h4C); send_byte(8'h1F); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst_wen", 32'(dbg_wen), 32'd0);
    check("mrst_addr", 32'(dbg_addr), 32'h0010);
    check("mrst_wdata", 32'(dbg_wdata), 32'h00);
    check("mrst_tx_valid", 32'(tx_valid), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mrst_writes", 32'(wa.size() - w0), 32'd1);
    check("mrst_idle_tx", 32'(tx_valid), 32'd0);
    check("mrst_rx_ready", 32'(rx_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
